ramp_envelope_gen: RTL and testbench
====================================

Name: ramp_envelope_gen

Overview:
- Per-channel DAC amplitude envelope generator that consumes the per-channel enable_ramping and start_ramp_down bits.
- Scales the channel's signed DAC sample stream by a linear 0→1 ramp at start, holds at unity, and ramps 1→0 on request.
- Reports ramp status back to the PS status register and the sequencer.
- One instance per DAC channel, between the waveform sum stage and the DAC output register.

Parameters:
- DATA_WIDTH, 16, signed sample width in/out.
- ACC_WIDTH, 32, ramp phase accumulator width; factor = acc[ACC_WIDTH-1 -: 16].

Ports:
- clk  in  1  DAC clock (125 MHz).
- reset  in  1  synchronous, active-high reset.
- dac_enable  in  1  channel output enable; low forces IDLE.
- enable_ramping  in  1  1 = use envelope; 0 = hard switch.
- start_ramp_down  in  1  level; rising edge requests ramp-down.
- ramp_step  in  ACC_WIDTH  accumulator increment per cycle; sampled at each ramp start.
- sample_in  in  DATA_WIDTH  signed sample.
- sample_out  out  DATA_WIDTH  signed scaled sample.
- ramp_state  out  3  0 IDLE, 1 RAMP_UP, 2 HOLD, 3 RAMP_DOWN, 4 DONE.
- ramp_up_done  out  1  one-cycle pulse on RAMP_UP→HOLD.
- ramp_down_done  out  1  sticky; set on entry to DONE, cleared in IDLE.

Behaviour:
- Reset values: sample_out=0, ramp_state=IDLE, ramp_up_done=0, ramp_down_done=0, accumulator=0, latched step=0.
- Reset and dac_enable=0 both take priority over all other inputs and abort any ramp immediately.
- Edge detection: start_ramp_down is registered; edge = in & ~prev. prev resets to 0.
  - A level already high when leaving IDLE is not an edge.
- IDLE:
  - acc=0.
  - On dac_enable=1 with enable_ramping=1 and ramp_step≠0: latch step, go to RAMP_UP.
  - Otherwise (ramp_step=0 or enable_ramping=0): acc=max, go to HOLD.
- RAMP_UP:
  - acc += step each cycle.
  - If the sum carries out or equals max, clamp acc=max (all ones), go to HOLD, pulse ramp_up_done.
- HOLD: the start_ramp_down edge leads to one of two states.
  - enable_ramping=1 and step≠0: go to RAMP_DOWN.
  - Otherwise: acc=0, go to DONE.
- RAMP_DOWN:
  - acc -= step each cycle.
  - On borrow or result 0, clamp acc=0 and go to DONE.
- start_ramp_down edge during RAMP_UP: go to RAMP_DOWN from the current acc (no jump). ramp_up_done does not pulse.
- DONE:
  - acc=0, ramp_down_done=1.
  - Stays until dac_enable=0 (→ IDLE). Further edges are ignored.
- enable_ramping changing mid-ramp has no effect until the next IDLE exit or ramp-down request.
- Scaling:
  - factor = acc[31:16] as unsigned Q0.16.
  - product = sample_in × {0,factor} (signed 17-bit operand, 33-bit result).
  - sample_out = product >>> 16 (arithmetic shift, truncate toward −inf).
  - In HOLD, sample_out = sample_in exactly (bypass, no 0xFFFF/0x10000 loss).
  - In IDLE/DONE, sample_out = 0.
- Latency:
  - sample_in → sample_out is 2 cycles in every state.
  - The state/factor used for a sample is the one registered in the sample's input cycle, so mode changes align with the sample stream.
  - ramp_state updates one cycle after the triggering input.
- Ramp length: ceil(2^ACC_WIDTH / step) cycles in each direction.

Test Plan:
- Reset, then dac_enable=1, enable_ramping=1, step=0x01000000, sample_in=0x7FFF constant:
  - RAMP_UP for 256 cycles, output monotonically non-decreasing from 0.
  - ramp_up_done single pulse; then HOLD with output exactly 0x7FFF.
- From HOLD, start_ramp_down 0→1 with step 0x01000000, sample_in=−32768:
  - 256-cycle RAMP_DOWN; output magnitude non-increasing.
  - DONE with output 0; ramp_down_done stays 1 until dac_enable=0, then IDLE and flag clears.
- start_ramp_down edge at cycle 100 of RAMP_UP:
  - Immediate RAMP_DOWN from acc≈0x64000000; reaches DONE about 100 cycles later.
  - No ramp_up_done pulse.
- enable_ramping=0, dac_enable=1:
  - HOLD on the next cycle; sample_out=sample_in at 2-cycle latency.
  - start_ramp_down edge → DONE with output 0 after 2 cycles.
- step=0xFFFFFFFF and start_ramp_down held high before enable: one-cycle RAMP_UP then HOLD; the held-high level triggers no ramp-down.
- Synchronous reset asserted mid RAMP_DOWN and dac_enable drop mid RAMP_UP: next cycle IDLE, acc=0, output 0 within 2 cycles, all flags 0.

Source files
------------

// File: rtl/ramp_envelope_gen.sv
// Per-channel DAC amplitude envelope generator.
// Scales a signed sample stream by a linear 0->1 ramp at start, passes it
// through untouched while holding, and ramps 1->0 on request. The envelope
// phase lives in an accumulator whose top 16 bits form an unsigned Q0.16
// gain factor. Samples see a fixed 2-cycle latency in every state; the
// state and factor applied to a sample are those present in its input cycle.
module ramp_envelope_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dac_enable,
    input  logic                  enable_ramping,
    input  logic                  start_ramp_down,
    input  logic [ACC_WIDTH-1:0]  ramp_step,
    input  logic [DATA_WIDTH-1:0] sample_in,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic [2:0]            ramp_state,
    output logic                  ramp_up_done,
    output logic                  ramp_down_done
);

    localparam int FACTOR_WIDTH = 16;
    localparam int PROD_WIDTH   = DATA_WIDTH + FACTOR_WIDTH + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // Control state
    state_t                 state_reg, state_next;
    logic [ACC_WIDTH-1:0]   acc_reg, acc_next;
    logic [ACC_WIDTH-1:0]   step_reg, step_next;
    logic                   srd_prev_reg;
    logic                   ramp_up_done_reg, ramp_up_done_next;
    logic                   ramp_down_done_reg, ramp_down_done_next;

    // Accumulator arithmetic with one extra bit to expose carry / borrow
    logic                   srd_edge;
    logic [ACC_WIDTH:0]     acc_sum;
    logic [ACC_WIDTH:0]     acc_diff;

    assign srd_edge = start_ramp_down & ~srd_prev_reg;
    assign acc_sum  = {1'b0, acc_reg} + {1'b0, step_reg};
    assign acc_diff = {1'b0, acc_reg} - {1'b0, step_reg};

    // Next-state, accumulator and flag logic; dac_enable=0 overrides everything
    always_comb begin
        state_next        = state_reg;
        acc_next          = acc_reg;
        step_next         = step_reg;
        ramp_up_done_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                acc_next = '0;
                if (enable_ramping && (ramp_step != '0)) begin
                    step_next  = ramp_step;
                    state_next = ST_RAMP_UP;
                end else begin
                    // Hard switch: full gain straight away
                    acc_next   = ACC_MAX;
                    state_next = ST_HOLD;
                end
            end

            ST_RAMP_UP: begin
                if (srd_edge) begin
                    // Reverse from wherever the ramp currently is, no jump
                    state_next = ST_RAMP_DOWN;
                end else if (acc_sum[ACC_WIDTH] || (acc_sum[ACC_WIDTH-1:0] == ACC_MAX)) begin
                    acc_next          = ACC_MAX;
                    state_next        = ST_HOLD;
                    ramp_up_done_next = 1'b1;
                end else begin
                    acc_next = acc_sum[ACC_WIDTH-1:0];
                end
            end

            ST_HOLD: begin
                acc_next = ACC_MAX;
                if (srd_edge) begin
                    // A ramp-down request is a new ramp start: take the current step
                    if (enable_ramping && (ramp_step != '0)) begin
                        step_next  = ramp_step;
                        state_next = ST_RAMP_DOWN;
                    end else begin
                        acc_next   = '0;
                        state_next = ST_DONE;
                    end
                end
            end

            ST_RAMP_DOWN: begin
                if (acc_diff[ACC_WIDTH] || (acc_diff[ACC_WIDTH-1:0] == '0)) begin
                    acc_next   = '0;
                    state_next = ST_DONE;
                end else begin
                    acc_next = acc_diff[ACC_WIDTH-1:0];
                end
            end

            ST_DONE: begin
                acc_next = '0;
            end

            default: begin
                acc_next   = '0;
                state_next = ST_IDLE;
            end
        endcase

        if (!dac_enable) begin
            state_next        = ST_IDLE;
            acc_next          = '0;
            ramp_up_done_next = 1'b0;
        end

        ramp_down_done_next = (state_next == ST_DONE);
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= ST_IDLE;
            acc_reg            <= '0;
            step_reg           <= '0;
            srd_prev_reg       <= 1'b0;
            ramp_up_done_reg   <= 1'b0;
            ramp_down_done_reg <= 1'b0;
        end else begin
            state_reg          <= state_next;
            acc_reg            <= acc_next;
            step_reg           <= step_next;
            srd_prev_reg       <= start_ramp_down;
            ramp_up_done_reg   <= ramp_up_done_next;
            ramp_down_done_reg <= ramp_down_done_next;
        end
    end

    // Datapath stage 1: capture sample together with the state and gain of its cycle
    logic signed [DATA_WIDTH-1:0] s1_sample_reg;
    state_t                       s1_state_reg;
    logic [FACTOR_WIDTH-1:0]      s1_factor_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_sample_reg <= '0;
            s1_state_reg  <= ST_IDLE;
            s1_factor_reg <= '0;
        end else begin
            s1_sample_reg <= sample_in;
            s1_state_reg  <= state_reg;
            s1_factor_reg <= acc_reg[ACC_WIDTH-1 -: FACTOR_WIDTH];
        end
    end

    // Signed sample times unsigned factor (factor zero-extended to a positive signed operand)
    logic signed [PROD_WIDTH-1:0] sample_ext;
    logic signed [PROD_WIDTH-1:0] factor_ext;
    logic signed [PROD_WIDTH-1:0] product;
    logic [DATA_WIDTH-1:0]        scaled;
    logic                         unused_product_bits;

    assign sample_ext = {{(FACTOR_WIDTH + 1){s1_sample_reg[DATA_WIDTH-1]}}, s1_sample_reg};
    assign factor_ext = {{(DATA_WIDTH + 1){1'b0}}, s1_factor_reg};
    assign product    = sample_ext * factor_ext;
    // Arithmetic shift right by 16; the magnitude never exceeds DATA_WIDTH bits
    assign scaled     = product[FACTOR_WIDTH +: DATA_WIDTH];
    assign unused_product_bits = ^{product[PROD_WIDTH-1], product[FACTOR_WIDTH-1:0]};

    // Output select: scaled while ramping, exact bypass while holding, silence otherwise
    logic [DATA_WIDTH-1:0] sample_out_reg, sample_out_next;

    always_comb begin
        sample_out_next = '0;
        case (s1_state_reg)
            ST_RAMP_UP, ST_RAMP_DOWN: sample_out_next = scaled;
            ST_HOLD:                  sample_out_next = s1_sample_reg;
            default:                  sample_out_next = '0;
        endcase
    end

    // Datapath stage 2: output register
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_out_reg <= '0;
        end else begin
            sample_out_reg <= sample_out_next;
        end
    end

    assign sample_out     = sample_out_reg;
    assign ramp_state     = state_reg;
    assign ramp_up_done   = ramp_up_done_reg;
    assign ramp_down_done = ramp_down_done_reg;

endmodule

// File: tb/tb_ramp_envelope_gen.sv
// Self-checking bench for ramp_envelope_gen. Each scenario task drives one
// input set per cycle, pushes the expected output for that sample into a
// queue, and pops/compares it two cycles later when the DUT produces it.
// Expected gains come from closed-form accumulator values per scenario.
module tb_ramp_envelope_gen;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RU   = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dac_enable = 1'b0;
    logic        enable_ramping = 1'b0;
    logic        start_ramp_down = 1'b0;
    logic [31:0] ramp_step = 32'd0;
    logic [15:0] sample_in = 16'd0;
    logic [15:0] sample_out;
    logic [2:0]  ramp_state;
    logic        ramp_up_done;
    logic        ramp_down_done;

    logic signed [15:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    ramp_envelope_gen #(
        .DATA_WIDTH(16),
        .ACC_WIDTH(32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dac_enable     (dac_enable),
        .enable_ramping (enable_ramping),
        .start_ramp_down(start_ramp_down),
        .ramp_step      (ramp_step),
        .sample_in      (sample_in),
        .sample_out     (sample_out),
        .ramp_state     (ramp_state),
        .ramp_up_done   (ramp_up_done),
        .ramp_down_done (ramp_down_done)
    );

    always #4 clk = ~clk;

    // Reference gain: floor(sample * acc[31:16] / 65536)
    function automatic logic signed [15:0] scale(input logic signed [15:0] s, input logic [31:0] acc);
        longint p;
        longint f;
        f = longint'({16'd0, acc[31:16]});
        p = longint'(s) * f;
        return 16'(p >>> 16);
    endfunction

    task automatic test_reset();
        logic signed [15:0] e;
        for (int c = 0; c < 6; c++) begin
            reset = (c < 3);
            dac_enable = (c < 3);
            enable_ramping = 1'b1;
            ramp_step = 32'h0100_0000;
            sample_in = 16'h1234;
            exp_q.push_back(16'sd0);
            @(posedge clk); #1;
            if (exp_q.size() >= 2) begin
                e = exp_q.pop_front();
                checks++;
                if (sample_out !== e) begin
                    errors++;
                    $display("FAIL reset_sample c=%0d got=%0d expected=%0d", c, $signed(sample_out), e);
                end
            end
            if (c == 0) begin
                checks++;
                if (sample_out !== 16'd0) begin
                    errors++;
                    $display("FAIL reset_out_value got=%0d expected=0", $signed(sample_out));
                end
            end
            checks++;
            if (ramp_state !== S_IDLE) begin
                errors++;
                $display("FAIL reset_state c=%0d got=%0d expected=%0d", c, ramp_state, S_IDLE);
            end
            checks++;
            if ({ramp_up_done, ramp_down_done} !== 2'b00) begin
                errors++;
                $display("FAIL reset_flags c=%0d got=%b expected=00", c, {ramp_up_done, ramp_down_done});
            end
        end
        $display("test_reset: complete, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_ramp_up();
        logic signed [15:0] e;
        logic signed [15:0] x;
        logic [2:0] es;
        for (int c = 0; c < 261; c++) begin
            dac_enable = 1'b1;
            enable_ramping = 1'b1;
            start_ramp_down = 1'b0;
            ramp_step = 32'h0100_0000;
            sample_in = 16'h7FFF;
            if (c == 0) x = 16'sd0;
            else if (c <= 256) x = scale(16'sh7FFF, 32'(c - 1) << 24);
            else x = 16'sh7FFF;
            exp_q.push_back(x);
            @(posedge clk); #1;
            if (exp_q.size() >= 2) begin
                e = exp_q.pop_front();
                checks++;
                if (sample_out !== e) begin
                    errors++;
                    $display("FAIL ramp_up_sample c=%0d got=%0d expected=%0d", c, $signed(sample_out), e);
                end
            end
            es = (c < 256) ? S_RU : S_HOLD;
            checks++;
            if (ramp_state !== es) begin
                errors++;
                $display("FAIL ramp_up_state c=%0d got=%0d expected=%0d", c, ramp_state, es);
            end
            checks++;
            if (ramp_up_done !== (c == 256)) begin
                errors++;
                $display("FAIL ramp_up_done_pulse c=%0d got=%b expected=%b", c, ramp_up_done, (c == 256));
            end
        end
        $display("test_ramp_up: complete, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_ramp_down();
        logic signed [15:0] e;
        logic signed [15:0] x;
        logic [2:0] es;
        logic edn;
        for (int c = 0; c < 268; c++) begin
            dac_enable = (c < 264);
            enable_ramping = 1'b1;
            start_ramp_down = (c < 258) || (c >= 260);
            ramp_step = 32'h0100_0000;
            sample_in = 16'h8000;
            if (c == 0) x = -16'sd32768;
            else if (c <= 256) x = scale(-16'sd32768, 32'hFFFF_FFFF - (32'(c - 1) << 24));
            else x = 16'sd0;
            exp_q.push_back(x);
            @(posedge clk); #1;
            if (exp_q.size() >= 2) begin
                e = exp_q.pop_front();
                checks++;
                if (sample_out !== e) begin
                    errors++;
                    $display("FAIL ramp_down_sample c=%0d got=%0d expected=%0d", c, $signed(sample_out), e);
                end
            end
            es = (c < 256) ? S_RD : (c < 264) ? S_DONE : S_IDLE;
            edn = (c >= 256) && (c < 264);
            checks++;
            if (ramp_state !== es) begin
                errors++;
                $display("FAIL ramp_down_state c=%0d got=%0d expected=%0d", c, ramp_state, es);
            end
            checks++;
            if ({ramp_up_done, ramp_down_done} !== {1'b0, edn}) begin
                errors++;
                $display("FAIL ramp_down_flags c=%0d got=%b expected=%b", c, {ramp_up_done, ramp_down_done}, {1'b0, edn});
            end
        end
        $display("test_ramp_down: complete, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_interrupt_ramp_up();
        logic signed [15:0] e;
        logic signed [15:0] x;
        logic signed [15:0] s;
        logic [2:0] es;
        logic edn;
        for (int c = 0; c < 206; c++) begin
            s = 16'(c * 331 - 20000);
            dac_enable = (c < 204);
            enable_ramping = 1'b1;
            start_ramp_down = (c >= 101);
            ramp_step = 32'h0100_0000;
            sample_in = s;
            if (c == 0) x = 16'sd0;
            else if (c <= 101) x = scale(s, 32'(c - 1) << 24);
            else if (c <= 201) x = scale(s, 32'h6400_0000 - (32'(c - 102) << 24));
            else x = 16'sd0;
            exp_q.push_back(x);
            @(posedge clk); #1;
            if (exp_q.size() >= 2) begin
                e = exp_q.pop_front();
                checks++;
                if (sample_out !== e) begin
                    errors++;
                    $display("FAIL interrupt_sample c=%0d got=%0d expected=%0d", c, $signed(sample_out), e);
                end
            end
            es = (c <= 100) ? S_RU : (c <= 200) ? S_RD : (c < 204) ? S_DONE : S_IDLE;
            edn = (c >= 201) && (c < 204);
            checks++;
            if (ramp_state !== es) begin
                errors++;
                $display("FAIL interrupt_state c=%0d got=%0d expected=%0d", c, ramp_state, es);
            end
            checks++;
            if ({ramp_up_done, ramp_down_done} !== {1'b0, edn}) begin
                errors++;
                $display("FAIL interrupt_flags c=%0d got=%b expected=%b", c, {ramp_up_done, ramp_down_done}, {1'b0, edn});
            end
        end
        $display("test_interrupt_ramp_up: complete, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_hard_switch();
        logic signed [15:0] e;
        logic signed [15:0] x;
        logic signed [15:0] s;
        logic [2:0] es;
        logic edn;
        for (int c = 0; c < 12; c++) begin
            s = 16'(c * 5000 - 30000);
            dac_enable = (c < 10);
            enable_ramping = 1'b0;
            start_ramp_down = (c >= 6);
            ramp_step = 32'h0100_0000;
            sample_in = s;
            x = ((c >= 1) && (c <= 6)) ? s : 16'sd0;
            exp_q.push_back(x);
            @(posedge clk); #1;
            if (exp_q.size() >= 2) begin
                e = exp_q.pop_front();
                checks++;
                if (sample_out !== e) begin
                    errors++;
                    $display("FAIL hard_switch_sample c=%0d got=%0d expected=%0d", c, $signed(sample_out), e);
                end
            end
            es = (c <= 5) ? S_HOLD : (c <= 9) ? S_DONE : S_IDLE;
            edn = (c >= 6) && (c <= 9);
            checks++;
            if (ramp_state !== es) begin
                errors++;
                $display("FAIL hard_switch_state c=%0d got=%0d expected=%0d", c, ramp_state, es);
            end
            checks++;
            if ({ramp_up_done, ramp_down_done} !== {1'b0, edn}) begin
                errors++;
                $display("FAIL hard_switch_flags c=%0d got=%b expected=%b", c, {ramp_up_done, ramp_down_done}, {1'b0, edn});
            end
        end
        $display("test_hard_switch: complete, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_full_step();
        logic signed [15:0] e;
        logic signed [15:0] x;
        logic signed [15:0] s;
        logic [2:0] es;
        for (int c = 0; c < 9; c++) begin
            s = 16'(c * 7919 - 30000);
            dac_enable = (c >= 1);
            enable_ramping = 1'b1;
            start_ramp_down = 1'b1;
            ramp_step = 32'hFFFF_FFFF;
            sample_in = s;
            if (c <= 1) x = 16'sd0;
            else if (c == 2) x = scale(s, 32'd0);
            else x = s;
            exp_q.push_back(x);
            @(posedge clk); #1;
            if (exp_q.size() >= 2) begin
                e = exp_q.pop_front();
                checks++;
                if (sample_out !== e) begin
                    errors++;
                    $display("FAIL full_step_sample c=%0d got=%0d expected=%0d", c, $signed(sample_out), e);
                end
            end
            es = (c == 0) ? S_IDLE : (c == 1) ? S_RU : S_HOLD;
            checks++;
            if (ramp_state !== es) begin
                errors++;
                $display("FAIL full_step_state c=%0d got=%0d expected=%0d", c, ramp_state, es);
            end
            checks++;
            if ({ramp_up_done, ramp_down_done} !== {(c == 2), 1'b0}) begin
                errors++;
                $display("FAIL full_step_flags c=%0d got=%b expected=%b", c, {ramp_up_done, ramp_down_done}, {(c == 2), 1'b0});
            end
        end
        $display("test_full_step: complete, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_aborts();
        logic signed [15:0] e;
        logic signed [15:0] x;
        logic signed [15:0] s;
        logic [2:0] es;
        for (int c = 0; c < 74; c++) begin
            s = 16'(c * 1237 - 25000);
            reset = (c == 70);
            dac_enable = ((c >= 1) && (c < 42)) || ((c >= 46) && (c < 70));
            enable_ramping = 1'b1;
            start_ramp_down = (c >= 64);
            ramp_step = (c < 46) ? 32'h0100_0000 : 32'h1000_0000;
            sample_in = s;
            if (c == 0) x = s;
            else if (c == 1) x = 16'sd0;
            else if (c <= 42) x = scale(s, 32'(c - 2) << 24);
            else if (c <= 46) x = 16'sd0;
            else if (c <= 62) x = scale(s, 32'(c - 47) << 28);
            else if (c <= 64) x = s;
            else if (c <= 69) x = scale(s, 32'hFFFF_FFFF - (32'(c - 65) << 28));
            else x = 16'sd0;
            if (reset) begin
                // Reset clears the output register, so the sample still in flight is lost
                exp_q.delete();
                exp_q.push_back(16'sd0);
            end
            exp_q.push_back(x);
            @(posedge clk); #1;
            if (exp_q.size() >= 2) begin
                e = exp_q.pop_front();
                checks++;
                if (sample_out !== e) begin
                    errors++;
                    $display("FAIL aborts_sample c=%0d got=%0d expected=%0d", c, $signed(sample_out), e);
                end
            end
            if (c == 0) es = S_IDLE;
            else if (c <= 41) es = S_RU;
            else if (c <= 45) es = S_IDLE;
            else if (c <= 61) es = S_RU;
            else if (c <= 63) es = S_HOLD;
            else if (c <= 69) es = S_RD;
            else es = S_IDLE;
            checks++;
            if (ramp_state !== es) begin
                errors++;
                $display("FAIL aborts_state c=%0d got=%0d expected=%0d", c, ramp_state, es);
            end
            checks++;
            if ({ramp_up_done, ramp_down_done} !== {(c == 62), 1'b0}) begin
                errors++;
                $display("FAIL aborts_flags c=%0d got=%b expected=%b", c, {ramp_up_done, ramp_down_done}, {(c == 62), 1'b0});
            end
        end
        reset = 1'b0;
        $display("test_aborts: complete, checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_interrupt_ramp_up();
        test_hard_switch();
        test_full_step();
        test_aborts();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
